// File: rtl/ky11_pkg.sv
// KY11 switch conditioner shared types: lockout FSM states,
// key indices in priority order and the priority pick helper.
package ky11_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_GUARD
    } ky_state_e;

    localparam int NKEYS    = 6;
    localparam int K_START  = 0;
    localparam int K_BEGIN  = 1;
    localparam int K_LDADRS = 2;
    localparam int K_EXAM   = 3;
    localparam int K_DEP    = 4;
    localparam int K_CONT   = 5;
    localparam int K_HALT   = 6;

    typedef logic [NKEYS-1:0] key_vec_t;

    // Lowest index wins, so K_START..K_CONT order is the priority order
    function automatic key_vec_t pri_pick(input key_vec_t v);
        return v & (~v + key_vec_t'(1));
    endfunction

endpackage

// File: rtl/ky11_debounce.sv
// KY11 single-switch conditioner: 2-FF synchroniser plus stable-count debounce.
// The level flips only after DBNC_TICKS consecutive clocks of disagreement.
module ky11_debounce #(
    parameter int DBNC_TICKS = 500000,
    parameter int CNT_W      = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DBNC_TICKS - 1)) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/ky11_switch_cond.sv
// KY11 console front-end: debounced panel keys with one-at-a-time lockout.
// Define KY_REPEAT_EN to build the EXAM/DEP auto-repeat counter.
module ky11_switch_cond
    import ky11_pkg::*;
#(
    parameter int DBNC_TICKS   = 500000,
    parameter int CNT_W        = 24,
    parameter int REPEAT_TICKS = 12500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        raw_ldadrs,
    input  logic        raw_exam,
    input  logic        raw_dep,
    input  logic        raw_cont,
    input  logic        raw_start,
    input  logic        raw_begin,
    input  logic        raw_halt,
    input  logic [15:0] raw_swr,
    output logic        ldadrs_sw,
    output logic        exam_sw,
    output logic        dep_sw,
    output logic        cont_sw,
    output logic        start_sw,
    output logic        begin_sw,
    output logic        halt_sw,
    output logic [15:0] swr,
    output logic        sw_busy
);

    logic [NKEYS:0]   raw_all;
    logic [NKEYS:0]   deb_all;
    key_vec_t         deb_keys;
    key_vec_t         pick;
    key_vec_t         out_keys;
    logic             any_key;
    logic             sel_live;
    logic             rep_gap;
    logic             busy;
    ky_state_e        state_q;
    ky_state_e        state_d;
    key_vec_t         sel_q;
    key_vec_t         sel_d;
    logic [CNT_W-1:0] gcnt_q;
    logic [CNT_W-1:0] gcnt_d;
    logic [15:0]      swr1_q;
    logic [15:0]      swr2_q;

    assign raw_all[K_START]  = raw_start;
    assign raw_all[K_BEGIN]  = raw_begin;
    assign raw_all[K_LDADRS] = raw_ldadrs;
    assign raw_all[K_EXAM]   = raw_exam;
    assign raw_all[K_DEP]    = raw_dep;
    assign raw_all[K_CONT]   = raw_cont;
    assign raw_all[K_HALT]   = raw_halt;

    for (genvar i = 0; i <= NKEYS; i++) begin : g_dbnc
        ky11_debounce #(
            .DBNC_TICKS(DBNC_TICKS),
            .CNT_W     (CNT_W)
        ) u_dbnc (
            .clk    (clk),
            .reset  (reset),
            .raw_i  (raw_all[i]),
            .level_o(deb_all[i])
        );
    end

    assign deb_keys = deb_all[NKEYS-1:0];
    assign halt_sw  = deb_all[K_HALT];
    assign pick     = pri_pick(deb_keys);
    assign any_key  = |deb_keys;
    assign sel_live = |(sel_q & deb_keys);

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        gcnt_d   = gcnt_q;
        out_keys = '0;
        busy     = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                busy = any_key;
                if (any_key) begin
                    state_d  = S_ACTIVE;
                    sel_d    = pick;
                    out_keys = pick;
                end
            end
            S_ACTIVE: begin
                if (sel_live) begin
                    out_keys = rep_gap ? '0 : sel_q;
                end else begin
                    state_d = S_GUARD;
                    gcnt_d  = '0;
                end
            end
            S_GUARD: begin
                // Any key still down restarts the quiet period
                if (any_key) begin
                    gcnt_d = '0;
                end else if (gcnt_q == CNT_W'(DBNC_TICKS - 1)) begin
                    state_d = S_IDLE;
                    sel_d   = '0;
                    gcnt_d  = '0;
                end else begin
                    gcnt_d = gcnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = '0;
                gcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            gcnt_q  <= '0;
            swr1_q  <= '0;
            swr2_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gcnt_q  <= gcnt_d;
            swr1_q  <= raw_swr;
            swr2_q  <= swr1_q;
        end
    end

`ifdef KY_REPEAT_EN
    logic [CNT_W-1:0] rcnt_q;
    logic [CNT_W-1:0] rcnt_d;
    logic [1:0]       gap_q;
    logic [1:0]       gap_d;
    logic             rep_key;

    assign rep_key = sel_q[K_EXAM] | sel_q[K_DEP];
    assign rep_gap = |gap_q;

    always_comb begin
        rcnt_d = '0;
        gap_d  = '0;
        if (state_q == S_ACTIVE && sel_live && rep_key) begin
            gap_d = (gap_q != 2'd0) ? gap_q - 2'd1 : 2'd0;
            // Two-clock drop gives the SWTCH detector a fresh edge
            if (rcnt_q == CNT_W'(REPEAT_TICKS - 1)) begin
                rcnt_d = '0;
                gap_d  = 2'd2;
            end else begin
                rcnt_d = rcnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rcnt_q <= '0;
            gap_q  <= '0;
        end else begin
            rcnt_q <= rcnt_d;
            gap_q  <= gap_d;
        end
    end
`else
    assign rep_gap = 1'b0;
`endif

    assign start_sw  = out_keys[K_START];
    assign begin_sw  = out_keys[K_BEGIN];
    assign ldadrs_sw = out_keys[K_LDADRS];
    assign exam_sw   = out_keys[K_EXAM];
    assign dep_sw    = out_keys[K_DEP];
    assign cont_sw   = out_keys[K_CONT];
    assign swr       = swr2_q;
    assign sw_busy   = busy;

    a_onehot: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(out_keys));

    a_cnt_w: assert property (@(posedge clk)
        (64'(DBNC_TICKS) <= (64'd1 << CNT_W)) &&
        (64'(REPEAT_TICKS) <= (64'd1 << CNT_W)));

endmodule
